inst_cache: RTL and testbench

//   Direct-mapped instruction cache; responder side of the instruction-fetch interface driven by the issue unit.

---
 rtl/inst_cache_pkg.sv | 20 ++
 rtl/ic_line_store.sv | 78 +++++++
 rtl/inst_cache.sv | 208 ++++++++++++++++++++
 tb/tb_inst_cache.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_cache_pkg.sv
// rtl/inst_cache_pkg.sv - shared types and helpers for the instruction cache
//
// Purpose: FSM state encoding, data width and tag-width helper used by
//          inst_cache and ic_line_store.
package inst_cache_pkg;

    localparam int IC_DATA_W = 32;
    localparam int IC_ADDR_W = 32;

    typedef enum logic {
        IC_IDLE   = 1'b0,
        IC_REFILL = 1'b1
    } ic_state_e;

    // Tag bits left over after the byte offset, word select and index.
    function automatic int ic_tag_width(input int index_width, input int word_width);
        return IC_ADDR_W - index_width - word_width - 2;
    endfunction

endpackage

// File: rtl/ic_line_store.sv
// rtl/ic_line_store.sv - tag/valid/data arrays of the direct-mapped instruction cache
//
// Purpose: holds one tag, one valid bit and 2^WORD_WIDTH data words per line.
//          Combinational read by (index, word); synchronous word write,
//          synchronous valid set/clear; valid bits cleared asynchronously by rst_in.
// Ports:
//   clk_in, rst_in              clock, async active-high reset (valid bits only)
//   rd_index, rd_word           lookup address
//   rd_valid, rd_tag, rd_data   lookup result (combinational)
//   wr_en, wr_index, wr_word, wr_data   refill word write
//   set_valid, set_index, set_tag       mark a refilled line valid with its tag
//   clr_valid, clr_index                invalidate a line when its refill starts
module ic_line_store
    import inst_cache_pkg::*;
#(
    parameter int INDEX_WIDTH = 4,
    parameter int WORD_WIDTH  = 2,
    parameter int TAG_WIDTH   = 24
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    input  logic [WORD_WIDTH-1:0]  rd_word,
    output logic                   rd_valid,
    output logic [TAG_WIDTH-1:0]   rd_tag,
    output logic [IC_DATA_W-1:0]   rd_data,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [WORD_WIDTH-1:0]  wr_word,
    input  logic [IC_DATA_W-1:0]   wr_data,
    input  logic                   set_valid,
    input  logic [INDEX_WIDTH-1:0] set_index,
    input  logic [TAG_WIDTH-1:0]   set_tag,
    input  logic                   clr_valid,
    input  logic [INDEX_WIDTH-1:0] clr_index
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int WORDS = 1 << WORD_WIDTH;

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     valid_d;
    logic [TAG_WIDTH-1:0] tag_mem  [LINES];
    logic [IC_DATA_W-1:0] data_mem [LINES*WORDS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_word}];

    always_comb begin
        valid_d = valid_q;
        if (clr_valid) begin
            valid_d[clr_index] = 1'b0;
        end
        if (set_valid) begin
            valid_d[set_index] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset: nothing reads them while invalid.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            data_mem[{wr_index, wr_word}] <= wr_data;
        end
        if (set_valid) begin
            tag_mem[set_index] <= set_tag;
        end
    end

endmodule

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped instruction cache between issue unit and memory controller
//
// Purpose: answers fetch requests with one-cycle hit latency; on a miss it
//          refills the whole line word by word from the memory controller and
//          then re-looks up the current pc. Read-only.
// Optional feature: define ICACHE_STATS_EN to add ic_hit_cnt / ic_miss_cnt.
// Ports:
//   clk_in, rst_in                 clock, async active-high reset
//   rdy_in                         0 = freeze all state and outputs
//   clr_in                         mispredict flush (suppresses the IDLE lookup)
//   iu_to_ic_en, iu_to_ic_pc       fetch request
//   ic_to_iu_ready/_inst/_pc       fetch response, one cycle per response
//   ic_to_mc_en, ic_to_mc_addr     refill read request (level) and word address
//   mc_to_ic_ready, mc_to_ic_data  refill word
//   ic_hit_cnt, ic_miss_cnt        lookup statistics (ICACHE_STATS_EN only)
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_WIDTH = 4,
    parameter int WORD_WIDTH  = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clr_in,
    input  logic        iu_to_ic_en,
    input  logic [31:0] iu_to_ic_pc,
    output logic        ic_to_iu_ready,
    output logic [31:0] ic_to_iu_inst,
    output logic [31:0] ic_to_iu_pc,
    output logic        ic_to_mc_en,
    output logic [31:0] ic_to_mc_addr,
    input  logic        mc_to_ic_ready,
    input  logic [31:0] mc_to_ic_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] ic_hit_cnt,
    output logic [31:0] ic_miss_cnt
`endif
);

    localparam int TAG_WIDTH = ic_tag_width(INDEX_WIDTH, WORD_WIDTH);
    localparam int IDX_LO    = WORD_WIDTH + 2;
    localparam int TAG_LO    = INDEX_WIDTH + WORD_WIDTH + 2;

    ic_state_e              state_q, state_d;
    logic                   ready_q, ready_d;
    logic [31:0]            inst_q, inst_d;
    logic [31:0]            pc_q, pc_d;
    logic                   mc_en_q, mc_en_d;
    logic [31:0]            mc_addr_q, mc_addr_d;
    logic [WORD_WIDTH-1:0]  cnt_q, cnt_d;

    logic [INDEX_WIDTH-1:0] lk_index;
    logic [WORD_WIDTH-1:0]  lk_word;
    logic [TAG_WIDTH-1:0]   lk_tag;
    logic                   rd_valid;
    logic [TAG_WIDTH-1:0]   rd_tag;
    logic [31:0]            rd_data;
    logic                   hit;

    // Index and tag of the line being refilled come from mc_addr_q: the word
    // increments never carry out of the line before the last word is written.
    logic [INDEX_WIDTH-1:0] rf_index;
    logic [TAG_WIDTH-1:0]   rf_tag;

    logic wr_en, set_valid, clr_valid;
    logic hit_evt, miss_evt;

    assign lk_word  = iu_to_ic_pc[IDX_LO-1:2];
    assign lk_index = iu_to_ic_pc[TAG_LO-1:IDX_LO];
    assign lk_tag   = iu_to_ic_pc[31:TAG_LO];
    assign rf_index = mc_addr_q[TAG_LO-1:IDX_LO];
    assign rf_tag   = mc_addr_q[31:TAG_LO];
    assign hit      = rd_valid && (rd_tag == lk_tag);

    ic_line_store #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .WORD_WIDTH  (WORD_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
    ) u_store (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rd_index  (lk_index),
        .rd_word   (lk_word),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_index  (rf_index),
        .wr_word   (cnt_q),
        .wr_data   (mc_to_ic_data),
        .set_valid (set_valid),
        .set_index (rf_index),
        .set_tag   (rf_tag),
        .clr_valid (clr_valid),
        .clr_index (lk_index)
    );

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        inst_d    = inst_q;
        pc_d      = pc_q;
        mc_en_d   = mc_en_q;
        mc_addr_d = mc_addr_q;
        cnt_d     = cnt_q;
        wr_en     = 1'b0;
        set_valid = 1'b0;
        clr_valid = 1'b0;
        hit_evt   = 1'b0;
        miss_evt  = 1'b0;

        // rdy_in low leaves every default in place, including the store controls.
        if (rdy_in) begin
            case (state_q)
                IC_IDLE: begin
                    ready_d = 1'b0;
                    if (iu_to_ic_en && !clr_in) begin
                        if (hit) begin
                            ready_d = 1'b1;
                            inst_d  = rd_data;
                            pc_d    = iu_to_ic_pc;
                            hit_evt = 1'b1;
                        end else begin
                            mc_en_d   = 1'b1;
                            mc_addr_d = {iu_to_ic_pc[31:IDX_LO], {IDX_LO{1'b0}}};
                            cnt_d     = '0;
                            clr_valid = 1'b1;
                            miss_evt  = 1'b1;
                            state_d   = IC_REFILL;
                        end
                    end
                end
                IC_REFILL: begin
                    ready_d = 1'b0;
                    // clr_in is deliberately ignored: the controller cannot abort.
                    if (mc_to_ic_ready) begin
                        wr_en     = 1'b1;
                        cnt_d     = cnt_q + 1'b1;
                        mc_addr_d = mc_addr_q + 32'd4;
                        if (cnt_q == {WORD_WIDTH{1'b1}}) begin
                            set_valid = 1'b1;
                            mc_en_d   = 1'b0;
                            state_d   = IC_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IC_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IC_IDLE;
            ready_q   <= 1'b0;
            inst_q    <= '0;
            pc_q      <= '0;
            mc_en_q   <= 1'b0;
            mc_addr_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            inst_q    <= inst_d;
            pc_q      <= pc_d;
            mc_en_q   <= mc_en_d;
            mc_addr_q <= mc_addr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ic_to_iu_ready = ready_q;
    assign ic_to_iu_inst  = inst_q;
    assign ic_to_iu_pc    = pc_q;
    assign ic_to_mc_en    = mc_en_q;
    assign ic_to_mc_addr  = mc_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + {31'd0, hit_evt};
        miss_cnt_d = miss_cnt_q + {31'd0, miss_evt};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign ic_hit_cnt  = hit_cnt_q;
    assign ic_miss_cnt = miss_cnt_q;
`else
    logic unused_evt;
    assign unused_evt = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - randomized self-checking bench for inst_cache
module tb_inst_cache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clr_in;
    logic        iu_to_ic_en;
    logic [31:0] iu_to_ic_pc;
    logic        ic_to_iu_ready;
    logic [31:0] ic_to_iu_inst;
    logic [31:0] ic_to_iu_pc;
    logic        ic_to_mc_en;
    logic [31:0] ic_to_mc_addr;
    logic        mc_to_ic_ready;
    logic [31:0] mc_to_ic_data;
`ifdef ICACHE_STATS_EN
    logic [31:0] ic_hit_cnt;
    logic [31:0] ic_miss_cnt;
`endif

    always #5 clk_in = ~clk_in;

    inst_cache dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clr_in         (clr_in),
        .iu_to_ic_en    (iu_to_ic_en),
        .iu_to_ic_pc    (iu_to_ic_pc),
        .ic_to_iu_ready (ic_to_iu_ready),
        .ic_to_iu_inst  (ic_to_iu_inst),
        .ic_to_iu_pc    (ic_to_iu_pc),
        .ic_to_mc_en    (ic_to_mc_en),
        .ic_to_mc_addr  (ic_to_mc_addr),
        .mc_to_ic_ready (mc_to_ic_ready),
        .mc_to_ic_data  (mc_to_ic_data)
`ifdef ICACHE_STATS_EN
        ,
        .ic_hit_cnt     (ic_hit_cnt),
        .ic_miss_cnt    (ic_miss_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per-line valid/tag, plus expected statistics.
    bit          m_valid [16];
    logic [23:0] m_tag   [16];
    int unsigned m_hits;
    int unsigned m_miss;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hA5A55A5A;
    endfunction

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
        check({tag, "_hit_cnt"}, ic_hit_cnt, m_hits);
        check({tag, "_miss_cnt"}, ic_miss_cnt, m_miss);
`endif
    endtask

    // One fetch held until its response. clr_word / frz_word pick the refill
    // word during which a clr pulse / 3-cycle freeze happens (>=4 means never).
    task automatic fetch(input logic [31:0] pc, input int clr_word, input int frz_word, input bit rnd);
        int          idx;
        logic [23:0] tag;
        logic [31:0] base;
        int          words;
        int          budget;
        int          frz_left;
        bit          frozen;
        bit          clred;
        bit          m;
        idx      = int'(pc[7:4]);
        tag      = pc[31:8];
        base     = {pc[31:4], 4'h0};
        words    = 0;
        budget   = 0;
        frz_left = 0;
        frozen   = 0;
        clred    = 0;
        iu_to_ic_en    = 1'b1;
        iu_to_ic_pc    = pc;
        clr_in         = 1'b0;
        rdy_in         = 1'b1;
        mc_to_ic_ready = 1'b0;
        if (m_valid[idx] && m_tag[idx] == tag) begin
            tick;
            m_hits++;
            check("hit_ready", ic_to_iu_ready, 1);
            check("hit_inst", ic_to_iu_inst, mem_word(pc));
            check("hit_pc", ic_to_iu_pc, pc);
            check("hit_no_mc_en", ic_to_mc_en, 0);
        end else begin
            tick;
            m_miss++;
            m_valid[idx] = 1'b0;
            while (words < 4 && budget < 200) begin
                check("refill_mc_en", ic_to_mc_en, 1);
                check("refill_addr", ic_to_mc_addr, base + 32'(words * 4));
                check("refill_ready", ic_to_iu_ready, 0);
                clr_in = 1'b0;
                rdy_in = 1'b1;
                m = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (words == frz_word && !frozen) begin
                    frz_left = 3;
                    frozen   = 1;
                end
                if (frz_left > 0) begin
                    rdy_in = 1'b0;
                    m      = 1'b1;
                    frz_left--;
                end else if (words == clr_word && !clred) begin
                    clr_in = 1'b1;
                    clred  = 1;
                    m      = 1'b1;
                end
                mc_to_ic_ready = m;
                mc_to_ic_data  = rdy_in ? mem_word(base + 32'(words * 4)) : 32'hDEADBEEF;
                tick;
                budget++;
                if (rdy_in && m) words++;
            end
            if (words < 4) check("refill_timeout", words, 4);
            mc_to_ic_ready = 1'b0;
            mc_to_ic_data  = '0;
            clr_in         = 1'b0;
            rdy_in         = 1'b1;
            check("refill_done_mc_en", ic_to_mc_en, 0);
            check("refill_done_ready", ic_to_iu_ready, 0);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            tick;
            m_hits++;
            check("miss_ready", ic_to_iu_ready, 1);
            check("miss_inst", ic_to_iu_inst, mem_word(pc));
            check("miss_pc", ic_to_iu_pc, pc);
        end
    endtask

    task automatic idle_cycle(input logic en, input logic clr);
        iu_to_ic_en = en;
        clr_in      = clr;
        rdy_in      = 1'b1;
        tick;
        check("idle_ready", ic_to_iu_ready, 0);
        check("idle_mc_en", ic_to_mc_en, 0);
        clr_in = 1'b0;
    endtask

    logic [23:0] tag_pool [4];

    initial begin
        logic [31:0] pc;
        logic [31:0] held_pc;
        tag_pool[0] = 24'h000000;
        tag_pool[1] = 24'h000001;
        tag_pool[2] = 24'h00ABCD;
        tag_pool[3] = 24'hFFFFFF;
        model_reset();
        rst_in         = 1'b1;
        rdy_in         = 1'b1;
        clr_in         = 1'b0;
        iu_to_ic_en    = 1'b0;
        iu_to_ic_pc    = '0;
        mc_to_ic_ready = 1'b0;
        mc_to_ic_data  = '0;
        tick;
        tick;
        check("rst_ready", ic_to_iu_ready, 0);
        check("rst_inst", ic_to_iu_inst, 0);
        check("rst_pc", ic_to_iu_pc, 0);
        check("rst_mc_en", ic_to_mc_en, 0);
        check("rst_mc_addr", ic_to_mc_addr, 0);
        check_stats("rst");
        rst_in = 1'b0;
        tick;

        // Cold miss at 0x0, then a hit in the same line.
        fetch(32'h0, 9, 9, 1'b0);
        fetch(32'h8, 9, 9, 1'b0);
`ifdef ICACHE_STATS_EN
        check("t6_hit_cnt", ic_hit_cnt, 2);
        check("t6_miss_cnt", ic_miss_cnt, 1);
`endif

        // Same index, different tag: each evicts the other.
        fetch(32'h100, 9, 9, 1'b0);
        fetch(32'h0, 9, 9, 1'b0);
        fetch(32'h104, 9, 9, 1'b0);

        // Flush during the second refill word; line must still be valid.
        fetch(32'h240, 1, 9, 1'b0);
        idle_cycle(1'b0, 1'b0);
        fetch(32'h24C, 9, 9, 1'b0);

        // Freeze for three cycles mid-refill with memory data offered.
        fetch(32'h380, 9, 2, 1'b0);
        fetch(32'h384, 9, 9, 1'b0);

        // Freeze in IDLE: a held response must not change.
        held_pc     = 32'h384;
        rdy_in      = 1'b0;
        iu_to_ic_pc = 32'h7000;
        tick;
        tick;
        check("frz_idle_ready", ic_to_iu_ready, 1);
        check("frz_idle_pc", ic_to_iu_pc, held_pc);
        check("frz_idle_inst", ic_to_iu_inst, mem_word(held_pc));
        check("frz_idle_mc_en", ic_to_mc_en, 0);
        rdy_in = 1'b1;

        // Flush with a request that would miss: no lookup, no refill.
        idle_cycle(1'b1, 1'b1);

        // Top-of-memory line.
        fetch(32'hFFFFFFFC, 9, 9, 1'b0);
        fetch(32'hFFFFFFF0, 9, 9, 1'b0);
        check_stats("directed");

        // Random fetches with random memory latency, flushes and freezes.
        for (int n = 0; n < 300; n++) begin
            pc = {tag_pool[$urandom_range(0, 3)], 4'($urandom), 2'($urandom), 2'b00};
            fetch(pc, $urandom_range(0, 7), $urandom_range(0, 7), 1'b1);
            case ($urandom_range(0, 7))
                0: idle_cycle(1'b0, 1'b0);
                1: idle_cycle(1'b1, 1'b1);
                default: ;
            endcase
        end
        check_stats("random");

        // Reset in the middle of a refill: request drops at once, line invalid.
        pc = 32'h0055_5550;
        if (m_valid[5] && m_tag[5] == 24'h005555) pc = 32'h0066_6650;
        iu_to_ic_en    = 1'b1;
        iu_to_ic_pc    = pc;
        tick;
        mc_to_ic_ready = 1'b1;
        mc_to_ic_data  = mem_word({pc[31:4], 4'h0});
        tick;
        mc_to_ic_data  = mem_word({pc[31:4], 4'h4});
        tick;
        check("pre_rst_mc_en", ic_to_mc_en, 1);
        mc_to_ic_ready = 1'b0;
        rst_in         = 1'b1;
        #1;
        check("mid_rst_mc_en", ic_to_mc_en, 0);
        check("mid_rst_addr", ic_to_mc_addr, 0);
        check("mid_rst_ready", ic_to_iu_ready, 0);
        tick;
        rst_in = 1'b0;
        model_reset();
        check_stats("post_rst");
        fetch(pc, 9, 9, 1'b0);
        fetch(32'h0, 9, 9, 1'b1);
        check_stats("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
